// File: rtl/tt_instr_shim.sv
// TinyTapeout pin adapter: assembles chunked instructions into a FIFO for the core
// and time-multiplexes core output channels plus a status byte onto io_out.
module tt_instr_shim #(
    parameter int CHUNKS = 2,
    parameter int OUT_CH = 2,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            instr,
    output logic [7:0]            io_out,
    output logic [5*CHUNKS-1:0]   core_instr,
    output logic                  core_valid,
    input  logic                  core_ready,
    input  logic [8*OUT_CH-1:0]   core_out
);
    localparam int IW = 5 * CHUNKS;
    localparam int KW = 3;
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [3:0] OUT_CH4 = 4'(OUT_CH);

    logic [KW-1:0] k_q, k_d;
    logic [IW-1:0] shreg_q, shreg_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    sel_q, sel_d;
    logic [7:0]    io_out_q, io_out_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [IW-1:0] mem_q [DEPTH];

    logic          is_data, is_abort, is_sel, last, full, empty, pop, push_req, push_ok;
    logic [IW-1:0] word;

    always_comb begin
        is_data  = instr[5];
        is_abort = (instr == 6'b001111);
        is_sel   = (instr[5:4] == 2'b01);
        last     = (k_q == KW'(CHUNKS - 1));
        full     = (occ_q == OW'(DEPTH));
        empty    = (occ_q == '0);
        pop      = !empty && core_ready;
        push_req = is_data && last;
        // a full FIFO still takes the word when the head leaves in the same cycle
        push_ok  = push_req && (!full || pop);

        word = shreg_q;
        word[5*k_q +: 5] = instr[4:0];

        k_d     = k_q;
        shreg_d = shreg_q;
        ovf_d   = ovf_q;
        sel_d   = sel_q;
        if (is_data) begin
            if (last) begin
                k_d     = '0;
                shreg_d = '0;
                if (!push_ok) ovf_d = 1'b1;
            end else begin
                k_d     = k_q + KW'(1);
                shreg_d = word;
            end
        end else if (is_abort) begin
            k_d     = '0;
            shreg_d = '0;
            ovf_d   = 1'b0;
        end else if (is_sel && (instr[3:0] < OUT_CH4 || instr[3:0] == 4'hF)) begin
            sel_d = instr[3:0];
        end

        wptr_d = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop     ? rptr_q + PW'(1) : rptr_q;
        occ_d  = occ_q;
        if (push_ok && !pop)      occ_d = occ_q + OW'(1);
        else if (!push_ok && pop) occ_d = occ_q - OW'(1);

        io_out_d = '0;
        for (int unsigned c = 0; c < OUT_CH; c++) begin
            if (sel_q == 4'(c)) io_out_d = core_out[8*c +: 8];
        end
        if (sel_q == 4'hF) io_out_d = {full, empty, ovf_q, (k_q != '0), 4'(occ_q)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= '0;
            shreg_q  <= '0;
            ovf_q    <= 1'b0;
            sel_q    <= '0;
            io_out_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            occ_q    <= '0;
        end else begin
            k_q      <= k_d;
            shreg_q  <= shreg_d;
            ovf_q    <= ovf_d;
            sel_q    <= sel_d;
            io_out_q <= io_out_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wptr_q] <= word;
    end

    assign io_out     = io_out_q;
    assign core_valid = !empty;
    assign core_instr = empty ? '0 : mem_q[rptr_q];

endmodule

// File: tb/tb_tt_instr_shim.sv
// Randomized bench for tt_instr_shim against a queue-based reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_tt_instr_shim;
    localparam int CHUNKS = 2;
    localparam int OUT_CH = 2;
    localparam int DEPTH  = 4;
    localparam int IW     = 5 * CHUNKS;
    localparam int CW     = 8 * OUT_CH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    instr = '0;
    logic [7:0]    io_out;
    logic [IW-1:0] core_instr;
    logic          core_valid;
    logic          core_ready = 1'b0;
    logic [CW-1:0] core_out = '0;

    tt_instr_shim #(.CHUNKS(CHUNKS), .OUT_CH(OUT_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instr(instr), .io_out(io_out),
        .core_instr(core_instr), .core_valid(core_valid),
        .core_ready(core_ready), .core_out(core_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [IW-1:0] mq[$];
    int            mk;
    logic [IW-1:0] mword;
    bit            movf;
    int            msel;
    logic [7:0]    mio;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [7:0] nio;
        bit popping;
        int s;
        nio = '0;
        if (msel < OUT_CH) nio = core_out[8*msel +: 8];
        else if (msel == 15)
            nio = {(mq.size() == DEPTH), (mq.size() == 0), movf, (mk != 0), 4'(mq.size())};
        if (rst) begin
            mq.delete(); mk = 0; mword = '0; movf = 0; msel = 0; mio = '0;
        end else begin
            mio = nio;
            popping = (mq.size() != 0) && core_ready;
            if (instr[5]) begin
                mword = mword | (IW'(instr[4:0]) << (5 * mk));
                mk++;
                if (mk == CHUNKS) begin
                    if (mq.size() < DEPTH || popping) begin
                        if (popping) begin void'(mq.pop_front()); popping = 0; end
                        mq.push_back(mword);
                    end else movf = 1;
                    mk = 0; mword = '0;
                end
            end else if (instr == 6'h0F) begin
                mk = 0; mword = '0; movf = 0;
            end else if (instr[5:4] == 2'b01) begin
                s = int'(instr[3:0]);
                if (s < OUT_CH || s == 15) msel = s;
            end
            if (popping) void'(mq.pop_front());
        end
    endtask

    task automatic cyc(input logic [5:0] ins, input logic rdy, input logic rs);
        instr = ins; core_ready = rdy; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        check("io_out", 32'(io_out), 32'(mio));
        check("core_valid", 32'(core_valid), 32'(mq.size() != 0));
        check("core_instr", 32'(core_instr), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    endtask

    initial begin
        logic [5:0] ri;
        int r;
        mk = 0; mword = '0; movf = 0; msel = 0; mio = '0;

        cyc(6'h00, 0, 1); cyc(6'h00, 0, 1);
        check("reset_io_out", 32'(io_out), 32'h00);
        check("reset_valid", 32'(core_valid), 32'h0);
        for (int i = 0; i < 5; i++) cyc(6'h00, 0, 0);
        check("idle_io_out", 32'(io_out), 32'h00);
        cyc(6'h1F, 0, 0); cyc(6'h00, 0, 0);
        check("status_empty", 32'(io_out), 32'h40);

        cyc(6'h25, 0, 0); cyc(6'h2A, 0, 0);
        check("assembled_valid", 32'(core_valid), 32'h1);
        check("assembled_word", 32'(core_instr), 32'h145);
        cyc(6'h00, 0, 0);
        check("status_occ1", 32'(io_out), 32'h01);

        for (int i = 0; i < 4; i++) begin
            cyc(6'h20 | 6'(i), 0, 0); cyc(6'h30 | 6'(i), 0, 0);
        end
        cyc(6'h00, 0, 0);
        check("status_overflow", 32'(io_out), 32'hA4);
        cyc(6'h0F, 0, 0); cyc(6'h00, 0, 0);
        check("status_after_abort", 32'(io_out), 32'h84);

        cyc(6'h3C, 0, 0); cyc(6'h27, 1, 0);
        cyc(6'h00, 0, 0);
        check("full_push_pop", 32'(io_out), 32'h84);
        for (int i = 0; i < 4; i++) cyc(6'h00, 1, 0);
        check("drained", 32'(core_valid), 32'h0);

        cyc(6'h21, 0, 0); cyc(6'h00, 0, 0);
        check("partial_bit", 32'(io_out), 32'h50);
        cyc(6'h0F, 0, 0); cyc(6'h22, 0, 0); cyc(6'h23, 0, 0);
        check("abort_word", 32'(core_instr), 32'h062);
        cyc(6'h00, 1, 0);

        core_out = CW'(16'hBEEF);
        cyc(6'h10, 0, 0); cyc(6'h00, 0, 0);
        check("chan0", 32'(io_out), 32'hEF);
        cyc(6'h11, 0, 0); cyc(6'h00, 0, 0);
        check("chan1", 32'(io_out), 32'hBE);
        cyc(6'h15, 0, 0); cyc(6'h00, 0, 0);
        check("chan_bad_sel", 32'(io_out), 32'hBE);

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      ri = {1'b1, 5'($urandom)};
            else if (r == 6) ri = {2'b01, 4'($urandom)};
            else if (r == 7) ri = 6'h0F;
            else if (r == 8) ri = {2'b00, 4'($urandom_range(0, 14))};
            else             ri = 6'h00;
            core_out = CW'($urandom);
            cyc(ri, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
